// File: rtl/alu_req_driver_311_if.sv
// Request/ALU/response bundle between the ALU operand driver and its environment.
// master = the driver, slave = the requester, response consumer and ALU side.
interface alu_req_driver_311_if #(
    parameter int CNT_W = 8
);
    logic             Req_Valid_311;
    logic             Req_Ready_311;
    logic [3:0]       Req_Op_311;
    logic [3:0]       Req_A_311;
    logic [3:0]       Req_B_311;
    logic [3:0]       Alu_In1_311;
    logic [3:0]       Alu_In2_311;
    logic [3:0]       Alu_Sel_311;
    logic [7:0]       Alu_Out_311;
    logic             Rsp_Valid_311;
    logic             Rsp_Ready_311;
    logic [7:0]       Rsp_Data_311;
    logic             Rsp_Err_311;
    logic [CNT_W-1:0] Done_Cnt_311;

    modport master (
        input  Req_Valid_311, Req_Op_311, Req_A_311, Req_B_311, Alu_Out_311, Rsp_Ready_311,
        output Req_Ready_311, Alu_In1_311, Alu_In2_311, Alu_Sel_311,
               Rsp_Valid_311, Rsp_Data_311, Rsp_Err_311, Done_Cnt_311
    );

    modport slave (
        output Req_Valid_311, Req_Op_311, Req_A_311, Req_B_311, Alu_Out_311, Rsp_Ready_311,
        input  Req_Ready_311, Alu_In1_311, Alu_In2_311, Alu_Sel_311,
               Rsp_Valid_311, Rsp_Data_311, Rsp_Err_311, Done_Cnt_311
    );
endinterface

// File: rtl/alu_req_driver_311.sv
// Drives registered operands/select into the 4-bit combinational ALU, waits a
// settle time, captures the result and returns it over a valid/ready response.
module alu_req_driver_311 #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input logic                  Clk_311,
    input logic                  Rst_311,
    alu_req_driver_311_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } req_t;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    state_t           state_q, state_d;
    req_t             alu_q;
    rsp_t             rsp_q;
    logic             err_pend_q;
    logic [3:0]       settle_q;
    logic [CNT_W-1:0] done_q;
    logic             req_ready, rsp_valid, accept, capture, rsp_done;

    always_ff @(posedge Clk_311) begin
        if (Rst_311) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Req_Valid_311)  state_d = WAIT;
            WAIT:    if (settle_q == 4'd0)   state_d = RESP;
            RESP:    if (bus.Rsp_Ready_311)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs come straight from the state register, so no input
    // reaches an output combinationally.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        accept    = req_ready && bus.Req_Valid_311;
        capture   = (state_q == WAIT) && (settle_q == 4'd0);
        rsp_done  = rsp_valid && bus.Rsp_Ready_311;
    end

    always_ff @(posedge Clk_311) begin
        if (Rst_311) begin
            alu_q      <= '0;
            err_pend_q <= 1'b0;
            settle_q   <= '0;
            rsp_q      <= '0;
            done_q     <= '0;
        end else begin
            if (accept) begin
                alu_q      <= '{op: bus.Req_Op_311, a: bus.Req_A_311, b: bus.Req_B_311};
                err_pend_q <= ((bus.Req_Op_311 == 4'd3) || (bus.Req_Op_311 == 4'd4)) &&
                              (bus.Req_B_311 == 4'd0);
                settle_q   <= SETTLE_LD;
            end else if ((state_q == WAIT) && (settle_q != 4'd0)) begin
                settle_q <= settle_q - 4'd1;
            end
            // ALU is still driven on a zero divisor; its output is simply replaced.
            if (capture)
                rsp_q <= '{err: err_pend_q, data: (err_pend_q ? 8'hFF : bus.Alu_Out_311)};
            if (rsp_done)
                done_q <= done_q + CNT_W'(1);
        end
    end

    assign bus.Req_Ready_311 = req_ready;
    assign bus.Rsp_Valid_311 = rsp_valid;
    assign bus.Alu_In1_311   = alu_q.a;
    assign bus.Alu_In2_311   = alu_q.b;
    assign bus.Alu_Sel_311   = alu_q.op;
    assign bus.Rsp_Data_311  = rsp_q.data;
    assign bus.Rsp_Err_311   = rsp_q.err;
    assign bus.Done_Cnt_311  = done_q;
endmodule

// File: tb/tb_alu_req_driver_311.sv
// Two drivers (settle 1 and settle 4) each wired to a behavioural 4-bit ALU,
// checked by directed/random stimulus and a transaction-level monitor.
module tb_alu_req_driver_311;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rst, rv, rr, qr, sv, se;
    logic [1:0][3:0]       op, a, b, i1, i2, sl;
    logic [1:0][7:0]       sd;
    logic [1:0][CNT_W-1:0] dc;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic int st_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Team ALU: 8-bit result from 4-bit operands.
    function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [3:0] x, input logic [3:0] y);
        logic [7:0] xx, yy;
        xx = {4'h0, x};
        yy = {4'h0, y};
        case (s)
            4'd0:    return xx + yy;
            4'd1:    return xx - yy;
            4'd2:    return xx * yy;
            4'd3:    return (y == 4'd0) ? 8'h00 : xx / yy;
            4'd4:    return (y == 4'd0) ? 8'h00 : xx % yy;
            4'd5:    return xx << 1;
            4'd6:    return xx >> 1;
            4'd7:    return {4'h0, x[2:0], x[3]};
            4'd8:    return {4'h0, x[0], x[3:1]};
            4'd9:    return xx & yy;
            4'd10:   return xx | yy;
            4'd11:   return xx ^ yy;
            4'd12:   return {4'h0, ~(x | y)};
            4'd13:   return {4'h0, ~(x & y)};
            4'd14:   return {4'h0, ~(x ^ y)};
            default: return (x > y) ? 8'h01 : 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        alu_req_driver_311_if #(.CNT_W(CNT_W)) bus ();
        assign bus.Req_Valid_311 = rv[g];
        assign bus.Req_Op_311    = op[g];
        assign bus.Req_A_311     = a[g];
        assign bus.Req_B_311     = b[g];
        assign bus.Rsp_Ready_311 = rr[g];
        assign bus.Alu_Out_311   = alu_f(bus.Alu_Sel_311, bus.Alu_In1_311, bus.Alu_In2_311);
        assign qr[g] = bus.Req_Ready_311;
        assign sv[g] = bus.Rsp_Valid_311;
        assign sd[g] = bus.Rsp_Data_311;
        assign se[g] = bus.Rsp_Err_311;
        assign i1[g] = bus.Alu_In1_311;
        assign i2[g] = bus.Alu_In2_311;
        assign sl[g] = bus.Alu_Sel_311;
        assign dc[g] = bus.Done_Cnt_311;

        alu_req_driver_311 #(.SETTLE_CYCLES(g == 0 ? 1 : 4), .CNT_W(CNT_W)) dut (
            .Clk_311 (clk),
            .Rst_311 (rst[g]),
            .bus     (bus.master)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: a request is outstanding from its accept edge
    // until its response handshake; the response is due SETTLE edges after accept.
    logic [1:0]       m_busy, m_fresh, m_err;
    logic [1:0]       m_live = 2'b00;
    int               m_acc [2];
    logic [1:0][3:0]  m_a, m_b, m_op;
    logic [1:0][7:0]  m_data, m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sv_exp(input int d);
        return m_busy[d] && (cyc >= m_acc[d] + st_of(d));
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_live[d]) begin
                chk("mon_ready", 32'(qr[d]), 32'(!m_busy[d]));
                chk("mon_valid", 32'(sv[d]), 32'(sv_exp(d)));
                chk("mon_excl", 32'(qr[d] & sv[d]), 32'd0);
                chk("mon_alu", {20'h0, i1[d], i2[d], sl[d]}, {20'h0, m_a[d], m_b[d], m_op[d]});
                chk("mon_cnt", 32'(dc[d]), 32'(m_cnt[d]));
                if (sv_exp(d) || m_fresh[d])
                    chk("mon_rsp", {23'h0, se[d], sd[d]}, {23'h0, m_err[d], m_data[d]});
            end
            if (rst[d]) begin
                m_live[d]  <= 1'b1;
                m_busy[d]  <= 1'b0;
                m_fresh[d] <= 1'b1;
                m_err[d]   <= 1'b0;
                m_data[d]  <= 8'h00;
                m_cnt[d]   <= 8'h00;
                m_a[d]     <= 4'h0;
                m_b[d]     <= 4'h0;
                m_op[d]    <= 4'h0;
                m_acc[d]   <= 0;
            end else if (m_live[d]) begin
                if (!m_busy[d] && rv[d]) begin
                    m_busy[d]  <= 1'b1;
                    m_fresh[d] <= 1'b0;
                    m_acc[d]   <= cyc + 1;
                    m_a[d]     <= a[d];
                    m_b[d]     <= b[d];
                    m_op[d]    <= op[d];
                    m_err[d]   <= ((op[d] == 4'd3) || (op[d] == 4'd4)) && (b[d] == 4'd0);
                    m_data[d]  <= (((op[d] == 4'd3) || (op[d] == 4'd4)) && (b[d] == 4'd0)) ?
                                  8'hFF : alu_f(op[d], a[d], b[d]);
                end else if (sv_exp(d) && rr[d]) begin
                    m_busy[d] <= 1'b0;
                    m_cnt[d]  <= m_cnt[d] + 8'd1;
                end
            end
        end
    end

    task automatic do_op(input int d, input logic [3:0] o, input logic [3:0] aa, input logic [3:0] bb,
                         input logic [7:0] ed, input logic ee, input int hold);
        int n, lat;
        @(posedge clk); #1;
        rv[d] = 1'b1; op[d] = o; a[d] = aa; b[d] = bb; rr[d] = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!qr[d] && n < 50) begin n++; @(negedge clk); end
        chk("accept_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        rv[d] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!sv[d] && lat < 64) begin lat++; @(negedge clk); end
        chk("latency", lat, st_of(d));
        chk("rsp_data", 32'(sd[d]), 32'(ed));
        chk("rsp_err", 32'(se[d]), 32'(ee));
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rr[d] = 1'b1;
            @(negedge clk);
            chk("hold_data", 32'(sd[d]), 32'(ed));
            chk("hold_valid", 32'(sv[d]), 32'd1);
        end
        @(posedge clk); #1;
        rr[d] = 1'b0;
        @(negedge clk);
        chk("ready_after", 32'(qr[d]), 32'd1);
    endtask

    task automatic backpressure();
        int n, lat;
        @(posedge clk); #1;
        rv[1] = 1'b1; op[1] = 4'd11; a[1] = 4'hA; b[1] = 4'h6; rr[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!qr[1] && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        op[1] = 4'd9; a[1] = 4'd5; b[1] = 4'd3;
        lat = 0;
        @(negedge clk);
        while (!sv[1] && lat < 64) begin
            chk("bp_wait_rdy", 32'(qr[1]), 32'd0);
            lat++;
            @(negedge clk);
        end
        chk("bp_latency", lat, 4);
        chk("bp_data", 32'(sd[1]), 32'h0C);
        chk("bp_err", 32'(se[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", 32'(sd[1]), 32'h0C);
            chk("bp_hold_rdy", 32'(qr[1]), 32'd0);
            chk("bp_hold_vld", 32'(sv[1]), 32'd1);
        end
        rr[1] = 1'b1;
        @(posedge clk); #1;
        rr[1] = 1'b0;
        chk("bp_idle", 32'(qr[1]), 32'd1);
        chk("bp_sel_old", 32'(sl[1]), 32'd11);
        @(posedge clk); #1;
        rv[1] = 1'b0;
        chk("bp_acc2", 32'(qr[1]), 32'd0);
        chk("bp_alu_new", {20'h0, i1[1], i2[1], sl[1]}, {20'h0, 4'd5, 4'd3, 4'd9});
        lat = 0;
        @(negedge clk);
        while (!sv[1] && lat < 64) begin lat++; @(negedge clk); end
        chk("bp2_data", 32'(sd[1]), 32'h01);
        @(posedge clk); #1;
        rr[1] = 1'b1;
        @(posedge clk); #1;
        rr[1] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ro, ra, rb;
        logic       re;
        rst = 2'b11; rv = '0; rr = '0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(qr[d]), 32'd1);
            chk("rst_valid", 32'(sv[d]), 32'd0);
            chk("rst_data", 32'(sd[d]), 32'd0);
            chk("rst_err", 32'(se[d]), 32'd0);
            chk("rst_alu", {20'h0, i1[d], i2[d], sl[d]}, 32'd0);
            chk("rst_cnt", 32'(dc[d]), 32'd0);
        end

        do_op(0, 4'd0, 4'd9, 4'd7, 8'h10, 1'b0, 0);
        chk("add_cnt", 32'(dc[0]), 32'd1);
        do_op(0, 4'd1, 4'd3, 4'd5, 8'hFE, 1'b0, 1);
        do_op(0, 4'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 0);
        do_op(0, 4'd3, 4'd9, 4'd0, 8'hFF, 1'b1, 2);
        do_op(0, 4'd4, 4'd9, 4'd4, 8'h01, 1'b0, 0);
        do_op(1, 4'd4, 4'd7, 4'd0, 8'hFF, 1'b1, 0);

        backpressure();

        // Random operations on both drivers, with zero divisors biased in.
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 2; d++) begin
                ro = 4'($urandom_range(0, 15));
                ra = 4'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                re = ((ro == 4'd3) || (ro == 4'd4)) && (rb == 4'd0);
                do_op(d, ro, ra, rb, re ? 8'hFF : alu_f(ro, ra, rb), re, int'($urandom_range(0, 3)));
            end
        end

        // Reset while the request is still settling.
        @(posedge clk); #1;
        rv[0] = 1'b1; op[0] = 4'd2; a[0] = 4'd3; b[0] = 4'd3; rr[0] = 1'b0;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk("mid_rst_ready", 32'(qr[0]), 32'd1);
        chk("mid_rst_valid", 32'(sv[0]), 32'd0);
        chk("mid_rst_alu", {20'h0, i1[0], i2[0], sl[0]}, 32'd0);
        chk("mid_rst_cnt", 32'(dc[0]), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_rst_novld", 32'(sv[0]), 32'd0);
        end

        // Done counter wraps after 256 responses.
        for (int i = 0; i < 256; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_op(0, 4'd9, ra, rb, {4'h0, ra & rb}, 1'b0, 0);
            if (i == 254) chk("cnt_255", 32'(dc[0]), 32'd255);
        end
        chk("cnt_wrap", 32'(dc[0]), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
